fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_sequencer.sv | 75 +++++++
 tb/tb_fetch_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states,
// HALT opcode, default widths and prefetch queue depth.
package fetch_pkg;
    localparam int ADDR_W_DEF  = 8;
    localparam int INST_W_DEF  = 16;
    localparam int QUEUE_DEPTH = 2;

    localparam logic [4:0] HALT_OPCODE = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic is_halt_op(input logic [4:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {word, pc} entries; flush overrides push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int W = ADDR_W_DEF + INST_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] entry_in,
    output logic [W-1:0] head_out,
    output logic [1:0]   count,
    output logic         valid
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff;

    assign pop_eff = pop && (count_q != 2'd0);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = entry_in;
                    else                 e1_d = entry_in;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the count; shift only when full.
                    if (count_q == 2'd1) begin
                        e0_d = entry_in;
                    end else begin
                        e0_d = e1_q;
                        e1_d = entry_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head_out = e0_q;
    assign count    = count_q;
    assign valid    = count_q != 2'd0;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM and pc: pulls words from an external combinational ROM into a
// two-entry prefetch queue, stops after a HALT word, redirects on branch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halt
);
    localparam logic [1:0] FULL = 2'(QUEUE_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push, pop;
    logic [1:0]        count;
    logic [INST_W+ADDR_W-1:0] head;

    assign pop  = inst_valid && inst_ready;
    assign push = (state_q == ST_FETCH) && !branch_valid &&
                  ((count < FULL) || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (branch_valid) begin
            pc_d = branch_target;
            if (state_q == ST_HALTED) state_d = ST_FETCH;
        end else begin
            if (state_q == ST_IDLE && run) state_d = ST_FETCH;
            if (push) begin
                pc_d = pc_q + ADDR_W'(1);
                if (is_halt_op(rom_data[INST_W-1 -: 5])) state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(.W(INST_W + ADDR_W)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (branch_valid),
        .entry_in ({rom_data, pc_q}),
        .head_out (head),
        .count    (count),
        .valid    (inst_valid)
    );

    assign rom_addr = pc_q;
    assign inst_out = head[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc  = head[ADDR_W-1:0];
    assign halt     = state_q == ST_HALTED;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: startup, backpressure, branch into HALT, halt exit,
// address wrap, reset mid-stream and branch while idle.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, run, branch_valid, inst_ready, inst_valid, halt;
    logic [7:0]  rom_addr, branch_target, inst_pc;
    logic [15:0] rom_data, inst_out;
    logic        wrap_img;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (rom_addr)
            8'h00:   rom_data = 16'hC000;
            8'h01:   rom_data = 16'hC801;
            8'h02:   rom_data = 16'hD002;
            8'hFF:   rom_data = wrap_img ? 16'hC000 : 16'h9800;
            default: rom_data = {8'h01, rom_addr};
        endcase
    end

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .halt          (halt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_inst(input string tag, input logic [7:0] pc, input logic [15:0] word);
        chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
        chk({tag, ".pc"},    32'(inst_pc),    32'(pc));
        chk({tag, ".out"},   32'(inst_out),   32'(word));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; branch_valid = 1'b0; branch_target = 8'h00;
        inst_ready = 1'b0; wrap_img = 1'b0;

        // Startup: reset in cycle 0, run in cycle 1
        tick;                                         // cycle 1
        chk("rst.valid", 32'(inst_valid), 32'd0);
        chk("rst.halt",  32'(halt),       32'd0);
        chk("rst.addr",  32'(rom_addr),   32'd0);
        chk("rst.out",   32'(inst_out),   32'd0);
        chk("rst.pc",    32'(inst_pc),    32'd0);
        reset = 1'b0; run = 1'b1; inst_ready = 1'b1;
        tick; run = 1'b0;                             // cycle 2
        chk("start.c2.valid", 32'(inst_valid), 32'd0);
        tick; chk_inst("start.c3", 8'h00, 16'hC000);
        tick; chk_inst("start.c4", 8'h01, 16'hC801);

        // Backpressure: fresh start, inst_ready low cycles 3..8
        reset = 1'b1; inst_ready = 1'b0;
        tick; reset = 1'b0; run = 1'b1; inst_ready = 1'b1;   // cycle 1
        tick; run = 1'b0;                                     // cycle 2
        tick; inst_ready = 1'b0;                              // cycle 3
        chk_inst("bp.c3", 8'h00, 16'hC000);
        for (int c = 4; c <= 8; c++) begin
            tick;
            chk_inst($sformatf("bp.c%0d", c), 8'h00, 16'hC000);
            chk($sformatf("bp.c%0d.addr", c), 32'(rom_addr), 32'h02);
        end
        tick; inst_ready = 1'b1;                              // cycle 9
        chk_inst("bp.c9", 8'h00, 16'hC000);
        tick; chk_inst("bp.c10", 8'h01, 16'hC801);
        tick; chk_inst("bp.c11", 8'h02, 16'hD002);

        // Branch to HALT with a full queue and a transfer in the same cycle
        tick;                                                 // cycle 12
        chk("br.full.valid", 32'(inst_valid), 32'd1);
        branch_valid = 1'b1; branch_target = 8'hFF;
        tick; branch_valid = 1'b0;                            // cycle 13
        chk("br.c13.valid", 32'(inst_valid), 32'd0);
        chk("br.c13.addr",  32'(rom_addr),   32'hFF);
        tick;                                                 // cycle 14
        chk_inst("br.c14", 8'hFF, 16'h9800);
        chk("br.c14.halt", 32'(halt),     32'd1);
        chk("br.c14.addr", 32'(rom_addr), 32'h00);
        for (int c = 15; c <= 16; c++) begin
            tick;
            chk($sformatf("hlt.c%0d.valid", c), 32'(inst_valid), 32'd0);
            chk($sformatf("hlt.c%0d.halt", c),  32'(halt),       32'd1);
            chk($sformatf("hlt.c%0d.addr", c),  32'(rom_addr),   32'h00);
        end

        // Halt exit via branch to 0x01
        branch_valid = 1'b1; branch_target = 8'h01;           // cycle 16
        tick; branch_valid = 1'b0;                            // cycle 17
        chk("hx.c17.halt",  32'(halt),       32'd0);
        chk("hx.c17.valid", 32'(inst_valid), 32'd0);
        tick; chk_inst("hx.c18", 8'h01, 16'hC801);
        tick; chk_inst("hx.c19", 8'h02, 16'hD002);

        // Wrap through 0xFF -> 0x00
        wrap_img = 1'b1; branch_valid = 1'b1; branch_target = 8'hFE;
        tick; branch_valid = 1'b0;                            // cycle 20
        chk("wr.c20.valid", 32'(inst_valid), 32'd0);
        tick; chk_inst("wr.c21", 8'hFE, 16'h01FE);
        tick; chk_inst("wr.c22", 8'hFF, 16'hC000);
        tick; chk_inst("wr.c23", 8'h00, 16'hC000);
        inst_ready = 1'b0;

        // Reset with a full queue and a transfer in the same cycle
        tick;                                                 // cycle 24
        chk_inst("rm.c24", 8'h00, 16'hC000);
        inst_ready = 1'b1; reset = 1'b1;
        tick; reset = 1'b0;                                   // cycle 25
        chk("rm.c25.valid", 32'(inst_valid), 32'd0);
        chk("rm.c25.addr",  32'(rom_addr),   32'h00);
        chk("rm.c25.halt",  32'(halt),       32'd0);

        // Branch while idle loads pc only; run then fetches from it
        branch_valid = 1'b1; branch_target = 8'h02;
        tick; branch_valid = 1'b0;                            // cycle 26
        chk("idle.c26.valid", 32'(inst_valid), 32'd0);
        chk("idle.c26.addr",  32'(rom_addr),   32'h02);
        run = 1'b1;
        tick; run = 1'b0;                                     // cycle 27
        chk("idle.c27.valid", 32'(inst_valid), 32'd0);
        tick; chk_inst("idle.c28", 8'h02, 16'hD002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
